draw_sequencer: RTL and testbench
=================================

// Module: draw_sequencer
// PURPOSE
//  Downstream stage of the paddle, ball and brick drawers. Time-multiplexes their pixel streams onto one VGA adapter port.
//  Once per frame tick, grants clients in index order (0=paddle, 1=ball, 2=bricks) via per-client enable.
//  Waits for each granted client's done, then moves on. Forwards only the granted client's x/y/colour/plot, registered.
// PARAMETERS
//  NUM_CLIENTS     3       number of drawing clients, 1..8
//  FRAME_DIV       833333  clock cycles per frame tick (50 MHz / 60 Hz); minimum 2
//  TIMEOUT_CYCLES  4096    max cycles a grant may last before abort (DRAW_TIMEOUT_EN only)
// PORTS
//  clock          in   1          system clock, all logic on posedge
//  reset_n        in   1          asynchronous active-low reset
//  client_mask    in   N          1 = client participates this frame; sampled at frame start
//  client_x       in   8*N        client i x at [8i+7:8i]
//  client_y       in   7*N        client i y at [7i+6:7i]
//  client_colour  in   3*N        client i colour at [3i+2:3i]
//  client_plot    in   N          client i plot request
//  client_done    in   N          client i cycle-complete pulse/level
//  client_enable  out  N          one-hot grant (client enable_state input)
//  vga_x          out  8          pixel x to VGA adapter
//  vga_y          out  7          pixel y to VGA adapter
//  vga_colour     out  3          pixel colour
//  vga_plot       out  1          write enable to VGA adapter
//  frame_start    out  1          one-cycle pulse when a frame round begins
//  busy           out  1          high from frame_start until the round completes
//  overrun_count  out  8          saturating count of frame ticks dropped while busy
//  timeout_err    out  1          sticky: a client grant timed out (0 when macro absent)
// BEHAVIOUR
//  Reset: client_enable=0, vga_*=0, frame_start=0, busy=0, overrun_count=0, timeout_err=0, divider=0, state IDLE.
//  Reset mid-round forces IDLE immediately; no pixel is forwarded after reset assertion.
//  Divider: counts 0..FRAME_DIV-1; tick is high in the cycle it equals FRAME_DIV-1, then wraps to 0.
//  States: IDLE -> SELECT -> GRANT -> WAIT_DONE -> GAP -> SELECT ... -> IDLE.
//   IDLE: on tick latch client_mask into mask_q, pulse frame_start, busy=1, idx=0, go SELECT.
//   SELECT: find lowest idx>=current with mask_q[idx]=1 -> GRANT. If none remain -> IDLE with busy=0.
//    An all-zero mask still produces frame_start, then returns to IDLE two cycles later.
//   GRANT: client_enable[idx]=1 (one-hot) registered; go WAIT_DONE the next cycle.
//   WAIT_DONE: hold enable. When client_done[idx]=1: drop enable, idx++, go GAP.
//   GAP: one cycle with all enables 0, so clients see a falling edge. Then SELECT.
//  done from non-granted clients is ignored, as is done in the same cycle as entering GRANT.
//  Datapath: 1-cycle latency. vga_x/y/colour <= granted slice; vga_plot <= client_plot[idx] && enable asserted.
//   Outside WAIT_DONE, vga_plot=0 and vga_x/y/colour hold their last values.
//  Overrun: tick while busy is dropped (no queueing). overrun_count increments, saturating at 255.
//  Tick arriving in the same cycle the round returns to IDLE counts as overrun; it does not start a round.
// CONFIGURATION
//  DRAW_TIMEOUT_EN defined:
//   Grant counter is cleared on GRANT and counts in WAIT_DONE.
//   When it reaches TIMEOUT_CYCLES-1 without done: treat as done (drop enable, GAP, next client) and set timeout_err.
//   timeout_err is cleared only by reset.
//  DRAW_TIMEOUT_EN absent: no counter. WAIT_DONE waits indefinitely. timeout_err tied to 0.
// STRUCTURE
//  draw_defs.vh: state encodings (IDLE, SELECT, GRANT, WAIT_DONE, GAP), widths X_W=8, Y_W=7, C_W=3.
//  Sub-module frame_tick_gen (FRAME_DIV): divider plus tick output, reset_n async clear.
//  Top keeps the FSM, index/mask registers, output mux, overrun and timeout logic.
// TESTING (FRAME_DIV=16, TIMEOUT_CYCLES=8, N=3)
//  1. mask=3'b111; each client raises done 5 cycles after its enable.
//     -> enables one-hot 001,010,100 in order; 1 zero cycle between grants; busy falls after client 2.
//  2. Client 1 drives x=8'd40, y=7'd100, colour=3'b101, plot=1 while granted; clients 0/2 plot=1 with other values.
//     -> vga_* show exactly 40/100/101 one cycle later; no leakage from ungranted clients.
//  3. mask=3'b101 -> client 1 never enabled. mask=0 -> frame_start pulses, busy high 2 cycles, no enables.
//  4. Client 0 withholds done for 40 cycles.
//     -> ticks at 16 and 32 dropped, overrun_count=2; 300 such ticks -> count saturates at 255.
//  5. DRAW_TIMEOUT_EN, client 0 never done.
//     -> enable drops after 8 cycles, timeout_err=1, client 1 granted. Without macro, enable held and timeout_err=0.
//  6. Assert reset_n low mid WAIT_DONE.
//     -> enables, vga_plot, busy drop asynchronously. After release, first frame_start occurs after 16 cycles.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// draw_sequencer_pkg: FSM states, pixel field widths and the next-client picker.
package draw_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, SELECT, GRANT, WAIT_DONE, GAP} state_t;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;
    localparam logic [3:0] NONE = 4'd8;
    // Lowest set bit of mask at or above from; NONE when no client remains.
    function automatic logic [3:0] first_from(input logic [7:0] mask, input logic [3:0] from);
        first_from = NONE;
        for (int i = 7; i >= 0; i--)
            if (mask[i] && 4'(i) >= from) first_from = 4'(i);
    endfunction
endpackage

// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: client pixel streams, grants and the VGA adapter port.
interface draw_sequencer_if
    import draw_sequencer_pkg::*;
#(
    parameter int NUM_CLIENTS = 3
);
    logic [NUM_CLIENTS-1:0]     client_mask;
    logic [X_W*NUM_CLIENTS-1:0] client_x;
    logic [Y_W*NUM_CLIENTS-1:0] client_y;
    logic [C_W*NUM_CLIENTS-1:0] client_colour;
    logic [NUM_CLIENTS-1:0]     client_plot;
    logic [NUM_CLIENTS-1:0]     client_done;
    logic [NUM_CLIENTS-1:0]     client_enable;
    logic [X_W-1:0]             vga_x;
    logic [Y_W-1:0]             vga_y;
    logic [C_W-1:0]             vga_colour;
    logic                       vga_plot;
    logic                       frame_start;
    logic                       busy;
    logic [7:0]                 overrun_count;
    logic                       timeout_err;
    modport master (
        input  client_mask, client_x, client_y, client_colour, client_plot, client_done,
        output client_enable, vga_x, vga_y, vga_colour, vga_plot, frame_start, busy,
               overrun_count, timeout_err
    );
    modport slave (
        output client_mask, client_x, client_y, client_colour, client_plot, client_done,
        input  client_enable, vga_x, vga_y, vga_colour, vga_plot, frame_start, busy,
               overrun_count, timeout_err
    );
endinterface

// File: rtl/draw_sequencer_frame_tick_gen.sv
// frame_tick_gen: free-running 0..FRAME_DIV-1 divider, tick high on the last count.
module frame_tick_gen #(
    parameter int FRAME_DIV = 833333
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = $clog2(FRAME_DIV);
    logic [CW-1:0] count;
    assign tick = count == CW'(FRAME_DIV - 1);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) count <= '0;
        else count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: once per frame tick, grants drawing clients in index order onto one VGA port.
// Define DRAW_TIMEOUT_EN to abort grants that outlast TIMEOUT_CYCLES and flag timeout_err.
module draw_sequencer
    import draw_sequencer_pkg::*;
#(
    parameter int NUM_CLIENTS    = 3,
    parameter int FRAME_DIV      = 833333,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic              clock,
    input logic              reset_n,
    draw_sequencer_if.master bus
);
    if (NUM_CLIENTS < 1 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("draw_sequencer: unsupported NUM_CLIENTS or TIMEOUT_CYCLES");
    end
    state_t                 state;
    logic                   tick, expire, plot_sel, done_sel, en_sel;
    logic [NUM_CLIENTS-1:0] mask_q;
    logic [3:0]             idx, nxt, nxt_idle;
    logic [X_W-1:0]         x_sel;
    logic [Y_W-1:0]         y_sel;
    logic [C_W-1:0]         c_sel;

    frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (.clock(clock), .reset_n(reset_n), .tick(tick));

    always_comb begin
        nxt      = first_from(8'(mask_q), idx);
        nxt_idle = first_from(8'(bus.client_mask), 4'd0);
        x_sel    = '0;
        y_sel    = '0;
        c_sel    = '0;
        plot_sel = 1'b0;
        done_sel = 1'b0;
        en_sel   = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++)
            if (4'(i) == idx) begin
                x_sel    = bus.client_x[i*X_W +: X_W];
                y_sel    = bus.client_y[i*Y_W +: Y_W];
                c_sel    = bus.client_colour[i*C_W +: C_W];
                plot_sel = bus.client_plot[i];
                done_sel = bus.client_done[i];
                en_sel   = bus.client_enable[i];
            end
    end

`ifdef DRAW_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] gcnt;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) gcnt <= '0;
        else gcnt <= state == WAIT_DONE ? gcnt + 1'b1 : '0;
    assign expire = state == WAIT_DONE && gcnt == TW'(TIMEOUT_CYCLES - 1) && !done_sel;
`else
    assign expire = 1'b0;
`endif

    // The next grant is raised as SELECT is entered, so GAP is the only idle cycle between clients.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            mask_q            <= '0;
            idx               <= '0;
            bus.client_enable <= '0;
            bus.vga_x         <= '0;
            bus.vga_y         <= '0;
            bus.vga_colour    <= '0;
            bus.vga_plot      <= 1'b0;
            bus.frame_start   <= 1'b0;
            bus.busy          <= 1'b0;
            bus.overrun_count <= '0;
            bus.timeout_err   <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            bus.vga_plot    <= 1'b0;
            if (tick && bus.busy && bus.overrun_count != 8'hff)
                bus.overrun_count <= bus.overrun_count + 8'd1;
            if (state == WAIT_DONE) begin
                bus.vga_x      <= x_sel;
                bus.vga_y      <= y_sel;
                bus.vga_colour <= c_sel;
                bus.vga_plot   <= plot_sel && en_sel;
            end
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (tick && !bus.busy) begin
                        mask_q            <= bus.client_mask;
                        idx               <= '0;
                        bus.client_enable <= NUM_CLIENTS'(1) << nxt_idle;
                        bus.frame_start   <= 1'b1;
                        bus.busy          <= 1'b1;
                        state             <= SELECT;
                    end
                end
                SELECT: begin
                    idx   <= nxt;
                    state <= nxt < 4'(NUM_CLIENTS) ? GRANT : IDLE;
                end
                GRANT: state <= WAIT_DONE;
                WAIT_DONE:
                    if (done_sel || expire) begin
                        bus.client_enable <= '0;
                        bus.timeout_err   <= bus.timeout_err | expire;
                        idx               <= idx + 4'd1;
                        state             <= GAP;
                    end
                GAP: begin
                    bus.client_enable <= NUM_CLIENTS'(1) << nxt;
                    state             <= SELECT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed frames with a grant/pixel scoreboard checked by a negedge monitor.
module tb_draw_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int n_checks = 0;
    int n_fail = 0;
    int pix_count = 0;
    int delay[3];
    int en_cnt[3];
    logic [2:0] exp_grant[$];
    logic [17:0] exp_px[3];

    always #5 clk = ~clk;

    draw_sequencer_if #(.NUM_CLIENTS(3)) bus ();
    draw_sequencer #(.NUM_CLIENTS(3), .FRAME_DIV(16), .TIMEOUT_CYCLES(8)) dut (
        .clock(clk), .reset_n(rst_n), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 200);
        chk("frame_start_seen", bus.frame_start, 1);
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (bus.busy && n < bound) begin
            n++;
            @(negedge clk);
        end
        chk("busy_fell", bus.busy, 0);
    endtask

    // Client model: done rises once a client has been enabled for delay[i] cycles (0 = never).
    initial begin : clients
        logic [2:0] d;
        bus.client_done = '0;
        for (int i = 0; i < 3; i++) en_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                en_cnt[i] = bus.client_enable[i] ? en_cnt[i] + 1 : 0;
                d[i] = delay[i] != 0 && en_cnt[i] >= delay[i];
            end
            bus.client_done = d;
        end
    end

    initial begin : monitor
        logic [2:0] prev_en, e;
        int zeros, in_round, age, cur;
        prev_en = '0; zeros = 0; in_round = 0; age = 0; cur = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = '0; zeros = 0; in_round = 0;
            end else begin
                if (bus.frame_start) in_round = 0;
                if (bus.client_enable != 3'b0 && prev_en == 3'b0) begin
                    chk("grant_onehot", 32'($onehot(bus.client_enable)), 1);
                    if (exp_grant.size() == 0) chk("grant_unexpected", bus.client_enable, 0);
                    else begin
                        e = exp_grant.pop_front();
                        chk("grant_order", bus.client_enable, e);
                        for (int i = 0; i < 3; i++) if (e[i]) cur = i;
                    end
                    if (in_round > 0) chk("grant_gap", zeros, 1);
                    in_round++;
                    age = 0;
                end else age++;
                zeros = bus.client_enable == 3'b0 ? zeros + 1 : 0;
                if (bus.vga_plot) begin
                    pix_count++;
                    chk("pixel", {bus.vga_x, bus.vga_y, bus.vga_colour}, exp_px[cur]);
                    chk("pixel_latency", age >= 3, 1);
                end
                prev_en = bus.client_enable;
            end
        end
    end

    initial begin : stimulus
        int n, base;
        rst_n = 1'b1;
        bus.client_mask = '0;
        bus.client_plot = '0;
        bus.client_x = {8'd200, 8'd40, 8'd10};
        bus.client_y = {7'd7, 7'd100, 7'd20};
        bus.client_colour = {3'b110, 3'b101, 3'b010};
        exp_px[0] = {8'd10, 7'd20, 3'b010};
        exp_px[1] = {8'd40, 7'd100, 3'b101};
        exp_px[2] = {8'd200, 7'd7, 3'b110};
        for (int i = 0; i < 3; i++) delay[i] = 5;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_enable", bus.client_enable, 0);
        chk("rst_vga", {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}, 0);
        chk("rst_frame_start", bus.frame_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun_count, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        rst_n = 1'b1;
        // Empty mask: frame_start still pulses, busy for two cycles, no grants.
        wait_frame(n);
        chk("first_frame_cycles", n, 16);
        wait_idle(20, n);
        chk("busy_len_empty", n, 2);
        // All three clients, done 5 cycles after enable, all plotting.
        bus.client_mask = 3'b111;
        bus.client_plot = 3'b111;
        exp_grant.push_back(3'b001);
        exp_grant.push_back(3'b010);
        exp_grant.push_back(3'b100);
        base = pix_count;
        wait_frame(n);
        bus.client_mask = '0;
        wait_idle(60, n);
        chk("busy_len_full", n, 20);
        chk("pixels_full", pix_count - base, 9);
        chk("overrun_full", bus.overrun_count, 1);
        // Client 1 masked out.
        bus.client_mask = 3'b101;
        exp_grant.push_back(3'b001);
        exp_grant.push_back(3'b100);
        base = pix_count;
        wait_frame(n);
        bus.client_mask = '0;
        wait_idle(60, n);
        chk("busy_len_101", n, 14);
        chk("pixels_101", pix_count - base, 6);
        wait_frame(n);
        wait_idle(20, n);
        chk("busy_len_empty2", n, 2);
`ifdef DRAW_TIMEOUT_EN
        // Client 0 never completes: grant aborted, client 1 follows.
        bus.client_mask = 3'b011;
        delay[0] = 0;
        exp_grant.push_back(3'b001);
        exp_grant.push_back(3'b010);
        wait_frame(n);
        bus.client_mask = '0;
        n = 0;
        while (bus.client_enable == 3'b001 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_grant_len", n >= 8 && n <= 10, 1);
        chk("timeout_gap", bus.client_enable, 0);
        chk("timeout_err_set", bus.timeout_err, 1);
        @(negedge clk);
        chk("timeout_next_grant", bus.client_enable, 3'b010);
        wait_idle(60, n);
`else
        // Client 0 holds its grant for 40 cycles: two ticks dropped.
        rst_n = 1'b0;
        bus.client_mask = 3'b001;
        delay[0] = 40;
        exp_grant.push_back(3'b001);
        repeat (2) @(negedge clk);
        chk("rst_overrun_clear", bus.overrun_count, 0);
        rst_n = 1'b1;
        wait_frame(n);
        chk("frame_after_reset", n, 16);
        bus.client_mask = '0;
        wait_idle(100, n);
        chk("busy_len_slow", n, 43);
        chk("overrun_two", bus.overrun_count, 2);
        // Client 0 never done: grant held indefinitely, overrun saturates.
        bus.client_mask = 3'b001;
        delay[0] = 0;
        exp_grant.push_back(3'b001);
        wait_frame(n);
        bus.client_mask = '0;
        repeat (4900) @(negedge clk);
        chk("overrun_saturated", bus.overrun_count, 255);
        chk("grant_held", bus.client_enable, 3'b001);
        chk("busy_held", bus.busy, 1);
        chk("timeout_err_off", bus.timeout_err, 0);
        delay[0] = 1;
        wait_idle(20, n);
`endif
        // Reset asserted while client 0 is mid-draw.
        bus.client_mask = 3'b001;
        delay[0] = 0;
        exp_grant.push_back(3'b001);
        wait_frame(n);
        bus.client_mask = '0;
        repeat (4) @(negedge clk);
        chk("pre_rst_enable", bus.client_enable, 3'b001);
        chk("pre_rst_plot", bus.vga_plot, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_enable", bus.client_enable, 0);
        chk("async_rst_plot", bus.vga_plot, 0);
        chk("async_rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frame(n);
        chk("frame_after_midreset", n, 16);
        wait_idle(20, n);
        chk("scoreboard_drained", exp_grant.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
